// File: rtl/write_ptr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : write_ptr_ctrl_pkg
//  Description : Shared FIFO pointer definitions and the Gray encode helper
//                used by both the write-side and read-side controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package write_ptr_ctrl_pkg;

    localparam int unsigned C_ADDR_WIDTH_DEF = 4;
    localparam int unsigned C_GRAY_MAX_W     = 32;

    // Pointers carry one extra bit so that full and empty are distinguishable.
    function automatic int unsigned ptr_w(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic int unsigned depth(input int unsigned aw);
        return 1 << aw;
    endfunction

    function automatic logic [C_GRAY_MAX_W-1:0] bin2gray(input logic [C_GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage : write_ptr_ctrl_pkg
`default_nettype wire

// File: rtl/write_ptr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : write_ptr_ctrl_if
//  Description : Producer-side bundle of the FIFO write pointer controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface write_ptr_ctrl_if
    import write_ptr_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = C_ADDR_WIDTH_DEF
);
    localparam int unsigned C_PTR_W = ptr_w(ADDR_WIDTH);

    logic                  writeEnableIn;
    logic [C_PTR_W-1:0]    syncedReadPtrIn;
    logic [C_PTR_W-1:0]    almostFullThreshIn;
    logic                  clrErrIn;
    logic                  writeAcceptOut;
    logic [ADDR_WIDTH-1:0] writeAddrOut;
    logic [C_PTR_W-1:0]    writePtrOut;
    logic                  fifoFullOut;
    logic                  almostFullOut;
    logic [C_PTR_W-1:0]    fillLevelOut;
    logic                  overflowOut;

    modport master (
        output writeEnableIn, syncedReadPtrIn, almostFullThreshIn, clrErrIn,
        input  writeAcceptOut, writeAddrOut, writePtrOut, fifoFullOut,
               almostFullOut, fillLevelOut, overflowOut
    );

    modport slave (
        input  writeEnableIn, syncedReadPtrIn, almostFullThreshIn, clrErrIn,
        output writeAcceptOut, writeAddrOut, writePtrOut, fifoFullOut,
               almostFullOut, fillLevelOut, overflowOut
    );

endinterface : write_ptr_ctrl_if
`default_nettype wire

// File: rtl/write_ptr_ctrl_gray2bin.sv
`default_nettype none
// ============================================================================
//  Module      : gray2bin
//  Description : Combinational Gray-to-binary converter (XOR prefix).
//  Revision    : 1.0 - initial release
// ============================================================================
module gray2bin #(
    parameter int unsigned WIDTH = 5
) (
    input  wire logic [WIDTH-1:0] i_gray,
    output logic      [WIDTH-1:0] o_bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule : gray2bin
`default_nettype wire

// File: rtl/write_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : write_ptr_ctrl
//  Description : Write-domain pointer/flag controller of the async FIFO:
//                binary/Gray write pointers, full, fill level, almost-full
//                and sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_ptr_ctrl
    import write_ptr_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = C_ADDR_WIDTH_DEF
) (
    input  wire logic          writeClkIn,
    input  wire logic          writeRstIn,
    write_ptr_ctrl_if.slave    bus
);

    localparam int unsigned C_PTR_W = ptr_w(ADDR_WIDTH);

    logic [C_PTR_W-1:0] write_bin_q,  write_bin_d;
    logic [C_PTR_W-1:0] write_gray_q, write_gray_d;
    logic [C_PTR_W-1:0] fill_level_q, fill_level_d;
    logic               full_q,        full_d;
    logic               almost_full_q, almost_full_d;
    logic               overflow_q,    overflow_d;

    logic                    w_accept;
    logic [C_PTR_W-1:0]      w_read_bin;
    logic [C_PTR_W-1:0]      w_full_gray;
    logic [C_GRAY_MAX_W-1:0] w_gray_wide;

    gray2bin #(
        .WIDTH (C_PTR_W)
    ) u_rd_gray2bin (
        .i_gray (bus.syncedReadPtrIn),
        .o_bin  (w_read_bin)
    );

    always_comb begin
        w_accept      = bus.writeEnableIn & ~full_q;
        write_bin_d   = write_bin_q + {{(C_PTR_W-1){1'b0}}, w_accept};
        w_gray_wide   = bin2gray(C_GRAY_MAX_W'(write_bin_d));
        write_gray_d  = w_gray_wide[C_PTR_W-1:0];
        // The write pointer is exactly DEPTH ahead when its Gray code equals the
        // read Gray code with the top two bits inverted.
        w_full_gray   = {~bus.syncedReadPtrIn[C_PTR_W-1:C_PTR_W-2],
                          bus.syncedReadPtrIn[C_PTR_W-3:0]};
        full_d        = (write_gray_d == w_full_gray);
        fill_level_d  = write_bin_d - w_read_bin;
        almost_full_d = (bus.almostFullThreshIn != '0) &&
                        (fill_level_d >= bus.almostFullThreshIn);
        overflow_d    = (bus.writeEnableIn & full_q) | (overflow_q & ~bus.clrErrIn);
    end

    always_ff @(posedge writeClkIn) begin
        if (!writeRstIn) begin
            write_bin_q   <= '0;
            write_gray_q  <= '0;
            fill_level_q  <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            write_bin_q   <= write_bin_d;
            write_gray_q  <= write_gray_d;
            fill_level_q  <= fill_level_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.writeAcceptOut = w_accept;
    assign bus.writeAddrOut   = write_bin_q[ADDR_WIDTH-1:0];
    assign bus.writePtrOut    = write_gray_q;
    assign bus.fifoFullOut    = full_q;
    assign bus.almostFullOut  = almost_full_q;
    assign bus.fillLevelOut   = fill_level_q;
    assign bus.overflowOut    = overflow_q;

endmodule : write_ptr_ctrl
`default_nettype wire

// File: tb/tb_write_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_write_ptr_ctrl
//  Description : Directed, scoreboard-based bench for write_ptr_ctrl (DEPTH 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_write_ptr_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic [4:0] ptr;
        logic [3:0] addr;
        logic       full;
        logic       af;
        logic [4:0] lvl;
        logic       ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    write_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    write_ptr_ctrl #(.ADDR_WIDTH(AW)) dut (
        .writeClkIn (clk),
        .writeRstIn (rst_n),
        .bus        (bus.slave)
    );

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_bin   = 0;
    bit   m_full  = 1'b0;
    bit   m_ovf   = 1'b0;
    bit   m_valid = 1'b0;

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: expected state is queued before the edge and
    // compared after it.
    task automatic cycle(input bit rst, input bit we, input int rb, input int thresh, input bit clr);
        exp_t e;
        int   acc;
        int   nb;
        int   lvl;
        @(negedge clk);
        rst_n                  = rst;
        bus.writeEnableIn      = we;
        bus.syncedReadPtrIn    = to_gray(rb);
        bus.almostFullThreshIn = 5'(thresh);
        bus.clrErrIn           = clr;
        #1;
        acc = (we && !m_full) ? 1 : 0;
        if (m_valid) check("accept", 32'(bus.writeAcceptOut), 32'(acc));
        if (!rst) begin
            nb = 0; lvl = 0; e.full = 1'b0; e.af = 1'b0; e.ovf = 1'b0;
        end else begin
            nb    = (m_bin + acc) % 32;
            lvl   = (nb - (rb % 32) + 32) % 32;
            e.full = (lvl == DEPTH);
            e.af   = (thresh != 0) && (lvl >= thresh);
            e.ovf  = (we && m_full) || (m_ovf && !clr);
        end
        e.ptr  = to_gray(nb);
        e.addr = 4'(nb);
        e.lvl  = 5'(lvl);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("ptr",   32'(bus.writePtrOut),   32'(e.ptr));
        check("addr",  32'(bus.writeAddrOut),  32'(e.addr));
        check("full",  32'(bus.fifoFullOut),   32'(e.full));
        check("afull", 32'(bus.almostFullOut), 32'(e.af));
        check("level", 32'(bus.fillLevelOut),  32'(e.lvl));
        check("ovf",   32'(bus.overflowOut),   32'(e.ovf));
        m_bin   = nb;
        m_full  = e.full;
        m_ovf   = e.ovf;
        m_valid = 1'b1;
    endtask

    initial begin
        bus.writeEnableIn      = 1'b0;
        bus.syncedReadPtrIn    = '0;
        bus.almostFullThreshIn = '0;
        bus.clrErrIn           = 1'b0;

        // Reset held with a pending write request
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("rst_ptr",  32'(bus.writePtrOut),  32'd0);
        check("rst_addr", 32'(bus.writeAddrOut), 32'd0);

        // Fill to full from an empty FIFO
        repeat (15) cycle(1, 1, 0, 0, 0);
        check("fill15_full", 32'(bus.fifoFullOut), 32'd0);
        cycle(1, 1, 0, 0, 0);
        check("fill16_full", 32'(bus.fifoFullOut),  32'd1);
        check("fill16_ptr",  32'(bus.writePtrOut),  32'b11000);
        check("fill16_lvl",  32'(bus.fillLevelOut), 32'd16);
        cycle(1, 1, 0, 0, 0);
        check("ovf_ptr_hold", 32'(bus.writePtrOut), 32'b11000);
        check("ovf_set",      32'(bus.overflowOut), 32'd1);

        // Clear collides with a new overflow cause, then a clean clear
        cycle(1, 1, 0, 0, 1);
        check("clr_vs_set", 32'(bus.overflowOut), 32'd1);
        cycle(1, 0, 0, 0, 1);
        check("clr_done",   32'(bus.overflowOut), 32'd0);

        // Full release by one read-pointer step, then refill
        cycle(1, 0, 1, 0, 0);
        check("release_full", 32'(bus.fifoFullOut), 32'd0);
        cycle(1, 1, 1, 0, 0);
        check("refull", 32'(bus.fifoFullOut), 32'd1);

        // Mid-operation reset at writeBin = 7
        cycle(0, 0, 0, 0, 0);
        repeat (7) cycle(1, 1, 0, 12, 0);
        check("pre_rst_addr", 32'(bus.writeAddrOut), 32'd7);
        cycle(0, 1, 0, 12, 0);
        check("mid_rst_addr", 32'(bus.writeAddrOut), 32'd0);
        check("mid_rst_lvl",  32'(bus.fillLevelOut), 32'd0);

        // Almost-full at threshold 12
        repeat (11) cycle(1, 1, 0, 12, 0);
        check("af11", 32'(bus.almostFullOut), 32'd0);
        cycle(1, 1, 0, 12, 0);
        check("af12",     32'(bus.almostFullOut), 32'd1);
        check("af12_lvl", 32'(bus.fillLevelOut),  32'd12);
        repeat (4) cycle(1, 1, 0, 12, 0);
        check("af_full", 32'(bus.fifoFullOut), 32'd1);

        // Almost-full disabled all the way to full
        cycle(0, 0, 0, 0, 0);
        repeat (16) cycle(1, 1, 0, 0, 0);
        check("afdis_af",   32'(bus.almostFullOut), 32'd0);
        check("afdis_full", 32'(bus.fifoFullOut),   32'd1);

        // Pointer wrap: advance to writeBin=30 while the reader trails by two
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) cycle(1, 1, (i >= 2) ? i - 2 : 0, 0, 0);
        check("pre_wrap_ptr", 32'(bus.writePtrOut), 32'(to_gray(30)));
        repeat (4) cycle(1, 1, 28, 0, 0);
        check("wrap_addr", 32'(bus.writeAddrOut), 32'd2);
        check("wrap_ptr",  32'(bus.writePtrOut),  32'(to_gray(2)));
        check("wrap_lvl",  32'(bus.fillLevelOut), 32'd6);
        check("wrap_full", 32'(bus.fifoFullOut),  32'd0);
        cycle(1, 0, 2, 0, 0);
        check("wrap_empty_lvl", 32'(bus.fillLevelOut), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_write_ptr_ctrl
`default_nettype wire
